// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared widths, ALU control encodings and the control-bundle
//               field order used by the ID/EX and EX/MEM pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int c_WIDTH = 32;
    localparam int c_REGW  = 5;
    localparam int c_ALUCW = 3;

    localparam logic [c_ALUCW-1:0] c_ALU_ADD = 3'b010;
    localparam logic [c_ALUCW-1:0] c_ALU_SUB = 3'b110;
    localparam logic [c_ALUCW-1:0] c_ALU_AND = 3'b000;
    localparam logic [c_ALUCW-1:0] c_ALU_OR  = 3'b001;
    localparam logic [c_ALUCW-1:0] c_ALU_SLT = 3'b111;

    // Control bundle, MSB first: regwrite, memtoreg, memwrite, alusrc,
    // regdst, alucontrol. Pipeline registers pack/unpack in this order.
    localparam int c_CTRL_FLAGS = 5;

    typedef struct packed {
        logic               regwrite;
        logic               memtoreg;
        logic               memwrite;
        logic               alusrc;
        logic               regdst;
        logic [c_ALUCW-1:0] alucontrol;
    } ctrl_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/flopenrc.sv
`default_nettype none
// ============================================================================
// Module      : flopenrc
// Description : Parameterised flop with async reset, enable and sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear only takes effect on an enabled edge; callers fold clr into en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_q <= '0;
            end else begin
                r_q <= i_d;
            end
        end
    end

    assign o_q = r_q;

endmodule : flopenrc
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg
// Description : ID/EX pipeline register with stall, flush and valid tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_reg
    import mips_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int REGW  = c_REGW,
    parameter int ALUCW = c_ALUCW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             valid_d,
    input  logic [WIDTH-1:0] pc_plus4_d,
    input  logic [WIDTH-1:0] rd1_d,
    input  logic [WIDTH-1:0] rd2_d,
    input  logic [WIDTH-1:0] signimm_d,
    input  logic [REGW-1:0]  rs_d,
    input  logic [REGW-1:0]  rt_d,
    input  logic [REGW-1:0]  rd_d,
    input  logic             regwrite_d,
    input  logic             memtoreg_d,
    input  logic             memwrite_d,
    input  logic             alusrc_d,
    input  logic             regdst_d,
    input  logic [ALUCW-1:0] alucontrol_d,
    output logic             valid_e,
    output logic [WIDTH-1:0] pc_plus4_e,
    output logic [WIDTH-1:0] rd1_e,
    output logic [WIDTH-1:0] rd2_e,
    output logic [WIDTH-1:0] signimm_e,
    output logic [REGW-1:0]  rs_e,
    output logic [REGW-1:0]  rt_e,
    output logic [REGW-1:0]  rd_e,
    output logic             regwrite_e,
    output logic             memtoreg_e,
    output logic             memwrite_e,
    output logic             alusrc_e,
    output logic             regdst_e,
    output logic [ALUCW-1:0] alucontrol_e
);

    localparam int c_DATAW = 4 * WIDTH + 3 * REGW;
    localparam int c_CTRLW = c_CTRL_FLAGS + ALUCW;

    logic             w_en;
    logic             w_clr;
    logic [c_DATAW-1:0] w_data_d;
    logic [c_DATAW-1:0] w_data_q;
    logic [c_CTRLW-1:0] w_ctrl_raw;
    logic [c_CTRLW-1:0] w_ctrl_d;
    logic [c_CTRLW-1:0] w_ctrl_q;

    // Flush must beat stall, so it forces the enable as well as the clear.
    assign w_en  = ~stall_e | flush_e;
    assign w_clr = flush_e;

    assign w_data_d   = {pc_plus4_d, rd1_d, rd2_d, signimm_d, rs_d, rt_d, rd_d};
    assign w_ctrl_raw = {regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d,
                         alucontrol_d};
    // An invalid slot carries no side effects downstream.
    assign w_ctrl_d   = valid_d ? w_ctrl_raw : '0;

    flopenrc #(.WIDTH(1)) u_valid (
        .clk   (clk),
        .rst   (reset),
        .i_en  (w_en),
        .i_clr (w_clr),
        .i_d   (valid_d),
        .o_q   (valid_e)
    );

    flopenrc #(.WIDTH(c_DATAW)) u_data (
        .clk   (clk),
        .rst   (reset),
        .i_en  (w_en),
        .i_clr (w_clr),
        .i_d   (w_data_d),
        .o_q   (w_data_q)
    );

    flopenrc #(.WIDTH(c_CTRLW)) u_ctrl (
        .clk   (clk),
        .rst   (reset),
        .i_en  (w_en),
        .i_clr (w_clr),
        .i_d   (w_ctrl_d),
        .o_q   (w_ctrl_q)
    );

    assign {pc_plus4_e, rd1_e, rd2_e, signimm_e, rs_e, rt_e, rd_e} = w_data_q;
    assign {regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e,
            alucontrol_e} = w_ctrl_q;

endmodule : id_ex_reg
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_reg
// Description : Self-checking bench for id_ex_reg against a slot-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        alusrc;
        logic        regdst;
        logic [2:0]  aluc;
    } slot_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  stall, flush;
    slot_t din;
    slot_t obs;
    slot_t exp_s;
    int    checks = 0;
    int    failures = 0;

    logic             valid_e;
    logic [31:0]      pc_plus4_e, rd1_e, rd2_e, signimm_e;
    logic [4:0]       rs_e, rt_e, rd_e;
    logic             regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e;
    logic [2:0]       alucontrol_e;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk          (clk),
        .reset        (reset),
        .stall_e      (stall),
        .flush_e      (flush),
        .valid_d      (din.valid),
        .pc_plus4_d   (din.pc),
        .rd1_d        (din.rd1),
        .rd2_d        (din.rd2),
        .signimm_d    (din.imm),
        .rs_d         (din.rs),
        .rt_d         (din.rt),
        .rd_d         (din.rd),
        .regwrite_d   (din.regwrite),
        .memtoreg_d   (din.memtoreg),
        .memwrite_d   (din.memwrite),
        .alusrc_d     (din.alusrc),
        .regdst_d     (din.regdst),
        .alucontrol_d (din.aluc),
        .valid_e      (valid_e),
        .pc_plus4_e   (pc_plus4_e),
        .rd1_e        (rd1_e),
        .rd2_e        (rd2_e),
        .signimm_e    (signimm_e),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .rd_e         (rd_e),
        .regwrite_e   (regwrite_e),
        .memtoreg_e   (memtoreg_e),
        .memwrite_e   (memwrite_e),
        .alusrc_e     (alusrc_e),
        .regdst_e     (regdst_e),
        .alucontrol_e (alucontrol_e)
    );

    assign obs = {valid_e, pc_plus4_e, rd1_e, rd2_e, signimm_e, rs_e, rt_e, rd_e,
                  regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, alucontrol_e};

    task automatic chk(input string tag, input logic [151:0] o, input logic [151:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic slot_t rand_slot();
        slot_t s;
        s.valid    = 1'($urandom);
        s.pc       = $urandom;
        s.rd1      = $urandom;
        s.rd2      = $urandom;
        s.imm      = $urandom;
        s.rs       = 5'($urandom);
        s.rt       = 5'($urandom);
        s.rd       = 5'($urandom);
        s.regwrite = 1'($urandom);
        s.memtoreg = 1'($urandom);
        s.memwrite = 1'($urandom);
        s.alusrc   = 1'($urandom);
        s.regdst   = 1'($urandom);
        s.aluc     = 3'($urandom);
        return s;
    endfunction

    // Reference model: what the EX slot should hold after one clock edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (flush) begin
            exp_s = '0;
        end else if (!stall) begin
            exp_s = din;
            if (!din.valid) begin
                exp_s.regwrite = 1'b0;
                exp_s.memtoreg = 1'b0;
                exp_s.memwrite = 1'b0;
                exp_s.alusrc   = 1'b0;
                exp_s.regdst   = 1'b0;
                exp_s.aluc     = 3'b000;
            end
        end
        @(negedge clk);
        chk(tag, obs, exp_s);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        din   = rand_slot();
        exp_s = '0;
        #2;
        chk("reset_state", obs, '0);

        // Reset then capture
        @(negedge clk);
        reset = 1'b0;
        din = '0;
        din.valid = 1'b1;
        din.imm = 32'hFFFF_FFFF;
        din.rd1 = 32'h5;
        din.aluc = 3'b010;
        din.regwrite = 1'b1;
        step("first_capture");
        chk("first_signimm", 152'(signimm_e), 152'(32'hFFFF_FFFF));
        chk("first_rd1", 152'(rd1_e), 152'(32'h5));
        chk("first_aluc_valid", 152'({alucontrol_e, regwrite_e, valid_e}), 152'({3'b010, 1'b1, 1'b1}));

        // Stall hold for three cycles while inputs change
        din = rand_slot();
        din.valid = 1'b1;
        din.imm = 32'h0000_0F0F;
        din.memwrite = 1'b1;
        din.aluc = 3'b110;
        step("stall_load");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = rand_slot();
            step($sformatf("stall_hold_%0d", i));
            chk("stall_imm", 152'(signimm_e), 152'(32'h0000_0F0F));
            chk("stall_ctrl", 152'({memwrite_e, alucontrol_e, valid_e}), 152'({1'b1, 3'b110, 1'b1}));
        end
        stall = 1'b0;
        din = rand_slot();
        step("stall_release");

        // Flush inserts a bubble, then normal capture resumes
        din.valid = 1'b1;
        din.memwrite = 1'b1;
        step("flush_preload");
        flush = 1'b1;
        din = rand_slot();
        step("flush_bubble");
        chk("flush_zero", obs, '0);
        flush = 1'b0;
        din = rand_slot();
        din.valid = 1'b1;
        step("after_flush");

        // Flush and stall together: bubble, not hold
        stall = 1'b1;
        flush = 1'b1;
        din = rand_slot();
        step("flush_and_stall");
        chk("flush_stall_zero", obs, '0);
        stall = 1'b0;
        flush = 1'b0;

        // Invalid slot squashes control but passes datapath
        din = rand_slot();
        din.valid = 1'b0;
        din.regwrite = 1'b1;
        din.memwrite = 1'b1;
        din.rd2 = 32'hDEAD_BEEF;
        step("squash");
        chk("squash_ctrl", 152'({regwrite_e, memwrite_e, valid_e}), 152'(3'b000));
        chk("squash_rd2", 152'(rd2_e), 152'(32'hDEAD_BEEF));

        // Async reset pulse between edges
        din = rand_slot();
        din.valid = 1'b1;
        step("pre_async_reset");
        #1 reset = 1'b1;
        #1 chk("async_reset_clear", obs, '0);
        exp_s = '0;
        #1 reset = 1'b0;
        din = rand_slot();
        din.valid = 1'b1;
        step("post_async_reset");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            din = rand_slot();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            step($sformatf("rand_%0d", i));
        end
        stall = 1'b0;
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_ex_reg
`default_nettype wire
